sr_chiquito: RTL and testbench

- Small 8-bit universal shift register driven by an 8-bit opcode word.
- On each rising clock edge it decodes the opcode on `data` and either loads `data_in`, shifts, rotates, clears or holds its contents.
- Register state is presented on `q`.
- Used as a datapath helper in the processor project wherever a shift/load register is controlled by an instruction-style control byte.

---
 rtl/sr_chiquito.sv | 71 +++++++
 tb/tb_sr_chiquito.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sr_chiquito.sv
// ---------------------------------------------------------------------------
// sr_chiquito: small universal shift register steered by an 8-bit opcode.
//
// Every rising clock edge the full opcode byte on `data` is decoded (exact
// match) and the register is cleared, loaded from `data_in`, shifted
// left/right (logical or arithmetic) or held.  Unknown opcodes, 0x00 and
// X/unknown opcode bits all hold the current contents.
//
// Optional build macro: SR_CHIQUITO_ROTATE_EN
//   defined     -> 0x0D rotates left by one, 0x0F rotates right by one
//   not defined -> 0x0D and 0x0F fall through to HOLD
//
// Reset `rst` is synchronous, active-high and beats every opcode.
// `q` comes straight from the state flop, so there is no combinational path
// from any input to the output.
// ---------------------------------------------------------------------------
module sr_chiquito #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);

    // Opcode encodings, always compared against the whole control byte
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_LOAD  = 8'h07;
    localparam logic [7:0] OP_SHL   = 8'h09;
    localparam logic [7:0] OP_SHR   = 8'h0B;
    localparam logic [7:0] OP_ROL   = 8'h0D;
    localparam logic [7:0] OP_ROR   = 8'h0F;
    localparam logic [7:0] OP_ASR   = 8'h11;

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Next-state decode: hold by default so unknown or X opcodes never corrupt state
    always_comb begin
        shift_d = shift_q;
        case (data)
            OP_CLEAR: shift_d = '0;
            OP_LOAD:  shift_d = data_in;
            OP_SHL:   shift_d = {shift_q[WIDTH-2:0], 1'b0};
            OP_SHR:   shift_d = {1'b0, shift_q[WIDTH-1:1]};
            OP_ASR:   shift_d = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
`ifdef SR_CHIQUITO_ROTATE_EN
            OP_ROL:   shift_d = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
            OP_ROR:   shift_d = {shift_q[0], shift_q[WIDTH-1:1]};
`else
            OP_ROL:   shift_d = shift_q;
            OP_ROR:   shift_d = shift_q;
`endif
            default:  shift_d = shift_q;
        endcase
    end

    // State register with synchronous reset taking priority over any opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    // Output is the flop itself
    assign q = shift_q;

endmodule

// File: tb/tb_sr_chiquito.sv
// ---------------------------------------------------------------------------
// tb_sr_chiquito: directed, self-checking bench for sr_chiquito.
// Expected values are hand-computed constants.  Rotate expectations follow
// whether SR_CHIQUITO_ROTATE_EN is defined for this build.
// ---------------------------------------------------------------------------
module tb_sr_chiquito;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic [7:0] data_in;
    logic [7:0] q;

    int testCount;
    int failCount;

    sr_chiquito #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .data_in (data_in),
        .q       (q)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs, then let the requested number of rising edges pass;
    // returns 1 time unit after the last edge so outputs are settled
    task automatic applyStimulus(input logic r, input logic [7:0] op,
                                 input logic [7:0] din, input int edges);
        rst     = r;
        data    = op;
        data_in = din;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare q against a hand-computed value and count the result
    task automatic checkOutput(input string tag, input logic [7:0] expected);
        testCount++;
        assert (q === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed q=0x%02h expected q=0x%02h", tag, q, expected);
        end
    endtask

    // Linear sequence of directed steps
    initial begin
        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        data      = 8'h00;
        data_in   = 8'h00;

        // Reset overrides LOAD for two edges
        applyStimulus(1'b1, 8'h07, 8'h5A, 1); checkOutput("reset_edge1", 8'h00);
        applyStimulus(1'b1, 8'h07, 8'h5A, 1); checkOutput("reset_edge2", 8'h00);

        // Load 0x01 then shift left three times
        applyStimulus(1'b0, 8'h07, 8'h01, 1); checkOutput("load_01", 8'h01);
        applyStimulus(1'b0, 8'h09, 8'hFF, 1); checkOutput("shl_1", 8'h02);
        applyStimulus(1'b0, 8'h09, 8'hFF, 1); checkOutput("shl_2", 8'h04);
        applyStimulus(1'b0, 8'h09, 8'hFF, 1); checkOutput("shl_3", 8'h08);

        // Logical shift right down to zero
        applyStimulus(1'b0, 8'h0B, 8'h00, 1); checkOutput("shr_1", 8'h04);
        applyStimulus(1'b0, 8'h0B, 8'h00, 1); checkOutput("shr_2", 8'h02);
        applyStimulus(1'b0, 8'h0B, 8'h00, 1); checkOutput("shr_3", 8'h01);
        applyStimulus(1'b0, 8'h0B, 8'h00, 1); checkOutput("shr_4_zero", 8'h00);

        // MSB falls off on shift left
        applyStimulus(1'b0, 8'h07, 8'h80, 1); checkOutput("load_80", 8'h80);
        applyStimulus(1'b0, 8'h09, 8'h00, 1); checkOutput("shl_msb_out", 8'h00);

        // Arithmetic shift right replicates the sign bit
        applyStimulus(1'b0, 8'h07, 8'h80, 1); checkOutput("load_80_b", 8'h80);
        applyStimulus(1'b0, 8'h11, 8'h00, 1); checkOutput("asr_1", 8'hC0);
        applyStimulus(1'b0, 8'h11, 8'h00, 1); checkOutput("asr_2", 8'hE0);
        applyStimulus(1'b0, 8'h07, 8'h40, 1); checkOutput("load_40", 8'h40);
        applyStimulus(1'b0, 8'h11, 8'hFF, 1); checkOutput("asr_pos", 8'h20);

        // Logical shift right drops the LSB and fills with zero
        applyStimulus(1'b0, 8'h07, 8'h81, 1); checkOutput("load_81", 8'h81);
        applyStimulus(1'b0, 8'h0B, 8'h00, 1); checkOutput("shr_lsb_out", 8'h40);

        // Hold on 0x00 and on illegal opcodes, data_in ignored
        applyStimulus(1'b0, 8'h07, 8'hA5, 1); checkOutput("load_A5", 8'hA5);
        applyStimulus(1'b0, 8'h00, 8'hFF, 1); checkOutput("hold_00", 8'hA5);
        applyStimulus(1'b0, 8'hFF, 8'h00, 1); checkOutput("hold_FF", 8'hA5);
        applyStimulus(1'b0, 8'h08, 8'h3C, 1); checkOutput("hold_08", 8'hA5);
        applyStimulus(1'b0, 8'h87, 8'h3C, 1); checkOutput("hold_87_nearload", 8'hA5);
        applyStimulus(1'b0, 8'bxxxx_xxxx, 8'h3C, 1); checkOutput("hold_x", 8'hA5);
        applyStimulus(1'b0, 8'h01, 8'h5A, 1); checkOutput("clear", 8'h00);

        // Shifting left eight times from all ones empties the register
        applyStimulus(1'b0, 8'h07, 8'hFF, 1); checkOutput("load_FF", 8'hFF);
        applyStimulus(1'b0, 8'h09, 8'h00, 7); checkOutput("shl_x7", 8'h80);
        applyStimulus(1'b0, 8'h09, 8'h00, 1); checkOutput("shl_x8", 8'h00);

        // Rotate opcodes depend on the build
        applyStimulus(1'b0, 8'h07, 8'h81, 1); checkOutput("load_81_rot", 8'h81);
`ifdef SR_CHIQUITO_ROTATE_EN
        applyStimulus(1'b0, 8'h0D, 8'h00, 1); checkOutput("rol", 8'h03);
        applyStimulus(1'b0, 8'h07, 8'h81, 1); checkOutput("load_81_ror", 8'h81);
        applyStimulus(1'b0, 8'h0F, 8'h00, 1); checkOutput("ror", 8'hC0);
`else
        applyStimulus(1'b0, 8'h0D, 8'h00, 1); checkOutput("rol_hold", 8'h81);
        applyStimulus(1'b0, 8'h0F, 8'h00, 1); checkOutput("ror_hold", 8'h81);
`endif

        // Reset in the middle of a shift-left run, then shifting resumes from zero
        applyStimulus(1'b0, 8'h07, 8'h03, 1); checkOutput("load_03", 8'h03);
        applyStimulus(1'b0, 8'h09, 8'h00, 1); checkOutput("mid_shl_1", 8'h06);
        applyStimulus(1'b1, 8'h09, 8'h00, 1); checkOutput("mid_reset", 8'h00);
        applyStimulus(1'b0, 8'h09, 8'h00, 1); checkOutput("resume_shl", 8'h00);
        applyStimulus(1'b0, 8'h07, 8'h11, 1); checkOutput("reload_after_reset", 8'h11);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
